memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 7 +
 rtl/memory_access_mem_timer.sv | 20 ++
 rtl/memory_access.sv | 96 +++++++++
 tb/tb_memory_access.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared FSM state encoding and timeout default for memory_access
package memory_access_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam int TIMEOUT_CYC_DEF = 32;
endpackage

// File: rtl/memory_access_mem_timer.sv
// mem_timer: WAIT timeout counter; clr zeroes, en increments, expired flags count == TIMEOUT_CYC-1
module mem_timer
  import memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  assign expired = cnt_q == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/memory_access.sv
// memory_access: load/store stage with IDLE/ISSUE/WAIT handshake, alignment/conflict faults and WAIT timeout
module memory_access
  import memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        memrd_in,
  input  logic        memwrt_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] wdata_in,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        stall_out,
  output logic        valid_out,
  output logic [15:0] result_out,
  output logic        err_out
);
  logic [1:0] state_q, state_d;
  logic rd_q, rd_d, valid_q, valid_d, err_q, err_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic mem_op, legal, accept, expired;
  always_comb begin
    mem_op = memrd_in | memwrt_in;
    legal = state_q == ST_IDLE && valid_in && mem_op && !(memrd_in && memwrt_in) && !alu_in[0];
    accept = state_q == ST_ISSUE && !mem_stall;
    state_d = state_q;
    rd_d = rd_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    result_d = result_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    if (state_q == ST_IDLE && valid_in) begin
      if (legal) begin
        state_d = ST_ISSUE;
        rd_d = memrd_in;
        addr_d = alu_in;
        wdata_d = wdata_in;
      end else begin
        // any mem op that is not legal is a conflict or misalignment fault
        valid_d = 1'b1;
        err_d = mem_op;
        result_d = alu_in;
      end
    end else if (accept) begin
      state_d = ST_WAIT;
    end else if (state_q == ST_WAIT && (mem_done || expired)) begin
      // mem_done takes priority over a coincident timeout
      state_d = ST_IDLE;
      valid_d = 1'b1;
      err_d = !mem_done;
      result_d = mem_done && rd_q ? mem_rdata : addr_q;
    end
  end
  mem_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(state_q == ST_WAIT && !mem_done),
    .expired(expired)
  );
  assign mem_rd = state_q == ST_ISSUE && rd_q;
  assign mem_wr = state_q == ST_ISSUE && !rd_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_out = state_q != ST_IDLE || legal;
  assign valid_out = valid_q;
  assign err_out = err_q;
  assign result_out = result_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      rd_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      result_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      result_q <= result_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed table vectors plus hand sequences for stall, timeout, race and reset-abort
module tb_memory_access;
  logic clk, rst, valid_in, memrd_in, memwrt_in, mem_stall, mem_done;
  logic [15:0] alu_in, wdata_in, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, result_out;
  logic mem_rd, mem_wr, stall_out, valid_out, err_out;
  int checks = 0, failures = 0;
  memory_access #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memrd_in(memrd_in), .memwrt_in(memwrt_in),
    .alu_in(alu_in), .wdata_in(wdata_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_stall(mem_stall), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .stall_out(stall_out), .valid_out(valid_out),
    .result_out(result_out), .err_out(err_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic v, rd, wr, done;
    logic [15:0] alu, wd;
    logic ev, ee;
    logic [15:0] er;
    logic es;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    valid_in = 1'b1;
    memrd_in = rd;
    memwrt_in = wr;
    alu_in = a;
    wdata_in = d;
    #1;
    chk("start_stall", stall_out, 1);
    tick;
    valid_in = 1'b0;
    memrd_in = 1'b0;
    memwrt_in = 1'b0;
    alu_in = '0;
    wdata_in = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int rd_cnt;
    vt[0] = '{1, 0, 0, 0, 16'h1234, 16'h0000, 1, 0, 16'h1234, 0};
    vt[1] = '{1, 1, 1, 0, 16'h0010, 16'h0000, 1, 1, 16'h0010, 0};
    vt[2] = '{1, 0, 1, 0, 16'h0041, 16'h5555, 1, 1, 16'h0041, 0};
    vt[3] = '{1, 1, 0, 0, 16'h00FF, 16'h0000, 1, 1, 16'h00FF, 0};
    vt[4] = '{0, 1, 0, 1, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0};
    vt[5] = '{1, 0, 0, 0, 16'hFFFE, 16'h0000, 1, 0, 16'hFFFE, 0};
    rst = 1'b1; valid_in = 0; memrd_in = 0; memwrt_in = 0; mem_stall = 0; mem_done = 0;
    alu_in = '0; wdata_in = '0; mem_rdata = '0;
    tick;
    tick;
    chk("rst_valid", valid_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_result", result_out, 16'h0000);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_stall", stall_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in = vt[i].v; memrd_in = vt[i].rd; memwrt_in = vt[i].wr; mem_done = vt[i].done;
      alu_in = vt[i].alu; wdata_in = vt[i].wd;
      #1;
      chk($sformatf("vec%0d_stall", i), stall_out, vt[i].es);
      tick;
      chk($sformatf("vec%0d_valid", i), valid_out, vt[i].ev);
      chk($sformatf("vec%0d_err", i), err_out, vt[i].ee);
      if (vt[i].ev) chk($sformatf("vec%0d_result", i), result_out, vt[i].er);
      chk($sformatf("vec%0d_rd", i), mem_rd, 0);
      chk($sformatf("vec%0d_wr", i), mem_wr, 0);
    end
    valid_in = 0; memrd_in = 0; memwrt_in = 0; mem_done = 0;
    tick;
    // load with two stalled ISSUE cycles, done on the third WAIT cycle
    mem_stall = 1'b1;
    start(1, 0, 16'h0040, 16'h0000);
    rd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      mem_stall = i < 2;
      #1;
      if (mem_rd && !mem_wr) rd_cnt++;
      chk("ld_issue_stall", stall_out, 1);
      chk("ld_addr", mem_addr, 16'h0040);
      tick;
    end
    chk("ld_rd_cycles", rd_cnt[15:0], 16'd3);
    mem_stall = 1'b0;
    chk("ld_wait_rd", mem_rd, 0);
    chk("ld_wait_stall", stall_out, 1);
    chk("ld_wait_valid", valid_out, 0);
    tick;
    tick;
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    tick;
    mem_done = 1'b0; mem_rdata = 16'h0000;
    chk("ld_valid", valid_out, 1);
    chk("ld_err", err_out, 0);
    chk("ld_result", result_out, 16'hBEEF);
    chk("ld_stall_off", stall_out, 0);
    tick;
    chk("ld_pulse", valid_out, 0);
    // timeout after four WAIT cycles; valid_in during WAIT must be ignored
    start(1, 0, 16'h0080, 16'h0000);
    chk("to_rd", mem_rd, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      valid_in = i < 3; alu_in = 16'h9999;
      #1;
      chk("to_wait_valid", valid_out, 0);
      chk("to_wait_stall", stall_out, 1);
      tick;
    end
    valid_in = 1'b0; alu_in = '0;
    chk("to_valid", valid_out, 1);
    chk("to_err", err_out, 1);
    chk("to_result", result_out, 16'h0080);
    // mem_done coincides with the last countable WAIT cycle
    start(1, 0, 16'h0200, 16'h0000);
    tick;
    tick;
    tick;
    tick;
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    tick;
    mem_done = 1'b0; mem_rdata = 16'h0000;
    chk("race_valid", valid_out, 1);
    chk("race_err", err_out, 0);
    chk("race_result", result_out, 16'h5A5A);
    // store completes with address as result
    start(0, 1, 16'h0100, 16'hA5A5);
    chk("st_wr", mem_wr, 1);
    chk("st_rd", mem_rd, 0);
    chk("st_addr", mem_addr, 16'h0100);
    chk("st_wdata", mem_wdata, 16'hA5A5);
    tick;
    chk("st_wait_wr", mem_wr, 0);
    mem_done = 1'b1; mem_rdata = 16'h7777;
    tick;
    mem_done = 1'b0; mem_rdata = 16'h0000;
    chk("st_valid", valid_out, 1);
    chk("st_err", err_out, 0);
    chk("st_result", result_out, 16'h0100);
    // reset during WAIT, then a late mem_done
    start(1, 0, 16'h0300, 16'h0000);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'h1111;
    #1;
    chk("ab_stall", stall_out, 0);
    tick;
    mem_done = 1'b0; mem_rdata = 16'h0000;
    chk("ab_valid", valid_out, 0);
    chk("ab_err", err_out, 0);
    chk("ab_result", result_out, 16'h0000);
    chk("ab_rd", mem_rd, 0);
    chk("ab_wr", mem_wr, 0);
    chk("ab_addr", mem_addr, 16'h0000);
    chk("ab_wdata", mem_wdata, 16'h0000);
    tick;
    chk("ab_valid2", valid_out, 0);
    valid_in = 1'b1; alu_in = 16'h4321;
    tick;
    valid_in = 1'b0;
    chk("post_valid", valid_out, 1);
    chk("post_result", result_out, 16'h4321);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
